rgb_lcd_timing: RTL

Consumer end of the RGB pixel clock: the video timing generator and output stage for the parallel RGB LCD panel, clocked by the PLL pixel clock.
- Scans the H/V raster.
- Issues pixel-coordinate requests to the framebuffer, which has a fixed 1-cycle read latency.
- Drives the panel's hsync, vsync, de and pixel bus, all registered.

---
 rtl/rgb_lcd_pkg.sv | 39 +++
 rtl/rgb_lcd_axis_counter.sv | 32 +++
 rtl/rgb_lcd_timing.sv | 110 +++++++++++
 3 files changed

// File: rtl/rgb_lcd_pkg.sv
// rtl/rgb_lcd_pkg.sv - shared widths, default panel timing and colour-bar constants for rgb_lcd_timing
package rgb_lcd_pkg;

    localparam int X_WIDTH = 11;
    localparam int Y_WIDTH = 10;

    localparam int DEF_H_ACTIVE = 800;
    localparam int DEF_H_FP     = 40;
    localparam int DEF_H_SYNC   = 48;
    localparam int DEF_H_BP     = 40;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 13;
    localparam int DEF_V_SYNC   = 3;
    localparam int DEF_V_BP     = 29;

    localparam logic [15:0] COL_WHITE   = 16'hFFFF;
    localparam logic [15:0] COL_YELLOW  = 16'hFFE0;
    localparam logic [15:0] COL_CYAN    = 16'h07FF;
    localparam logic [15:0] COL_GREEN   = 16'h07E0;
    localparam logic [15:0] COL_MAGENTA = 16'hF81F;
    localparam logic [15:0] COL_RED     = 16'hF800;
    localparam logic [15:0] COL_BLUE    = 16'h001F;
    localparam logic [15:0] COL_BLACK   = 16'h0000;

    // Bars run left to right in this order.
    function automatic logic [15:0] bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    return COL_WHITE;
            3'd1:    return COL_YELLOW;
            3'd2:    return COL_CYAN;
            3'd3:    return COL_GREEN;
            3'd4:    return COL_MAGENTA;
            3'd5:    return COL_RED;
            3'd6:    return COL_BLUE;
            default: return COL_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/rgb_lcd_axis_counter.sv
// rtl/rgb_lcd_axis_counter.sv - one raster axis counter with active and sync region decode
module rgb_lcd_axis_counter #(
    parameter int W      = 11,
    parameter int ACTIVE = 800,
    parameter int FP     = 40,
    parameter int SYNC   = 48,
    parameter int BP     = 40
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         wrap,
    output logic         active,
    output logic         sync_on
);

    localparam int TOTAL = ACTIVE + FP + SYNC + BP;

    assign wrap    = en && (cnt == W'(TOTAL - 1));
    assign active  = (cnt < W'(ACTIVE));
    assign sync_on = (cnt >= W'(ACTIVE + FP)) && (cnt < W'(ACTIVE + FP + SYNC));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/rgb_lcd_timing.sv
// rtl/rgb_lcd_timing.sv - RGB LCD raster timing, framebuffer request and registered panel output
// Optional colour-bar generator enabled by defining RGB_LCD_TEST_PATTERN_EN.
module rgb_lcd_timing
    import rgb_lcd_pkg::*;
#(
    parameter int   H_ACTIVE    = DEF_H_ACTIVE,
    parameter int   H_FP        = DEF_H_FP,
    parameter int   H_SYNC      = DEF_H_SYNC,
    parameter int   H_BP        = DEF_H_BP,
    parameter int   V_ACTIVE    = DEF_V_ACTIVE,
    parameter int   V_FP        = DEF_V_FP,
    parameter int   V_SYNC      = DEF_V_SYNC,
    parameter int   V_BP        = DEF_V_BP,
    parameter logic HSYNC_POL   = 1'b0,
    parameter logic VSYNC_POL   = 1'b0,
    parameter int   PIXEL_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   req_valid,
    output logic [X_WIDTH-1:0]     req_x,
    output logic [Y_WIDTH-1:0]     req_y,
    output logic                   frame_start,
    input  logic [PIXEL_WIDTH-1:0] pixel_in,
    input  logic                   pattern_en,
    output logic                   lcd_hsync,
    output logic                   lcd_vsync,
    output logic                   lcd_de,
    output logic [PIXEL_WIDTH-1:0] lcd_rgb
);

    logic run;
    logic h_wrap, h_act, h_sync;
    logic v_act, v_sync;
    logic unused_v_wrap;

    logic v1, de1, hs1, vs1;
    logic [PIXEL_WIDTH-1:0] pix_sel;

    // Counters hold at (0,0) for the first edge after reset so that cycle shows the origin.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) run <= 1'b0;
        else       run <= 1'b1;
    end

    rgb_lcd_axis_counter #(
        .W(X_WIDTH), .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
    ) u_h_cnt (
        .clk(clk), .rst(reset), .en(run),
        .cnt(req_x), .wrap(h_wrap), .active(h_act), .sync_on(h_sync)
    );

    rgb_lcd_axis_counter #(
        .W(Y_WIDTH), .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
    ) u_v_cnt (
        .clk(clk), .rst(reset), .en(h_wrap),
        .cnt(req_y), .wrap(unused_v_wrap), .active(v_act), .sync_on(v_sync)
    );

    assign req_valid   = run & h_act & v_act;
    assign frame_start = run & (req_x == '0) & (req_y == '0);

`ifdef RGB_LCD_TEST_PATTERN_EN
    localparam int BAR_W = H_ACTIVE / 8;
    logic [X_WIDTH-1:0] x1;
    logic [2:0]         bar_idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) x1 <= '0;
        else       x1 <= req_x;
    end

    assign bar_idx = 3'(x1 / X_WIDTH'(BAR_W));
    assign pix_sel = pattern_en ? PIXEL_WIDTH'(bar_colour(bar_idx)) : pixel_in;
`else
    logic unused_pattern_en;
    assign unused_pattern_en = pattern_en;
    assign pix_sel = pixel_in;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1  <= 1'b0;
            de1 <= 1'b0;
            hs1 <= 1'b0;
            vs1 <= 1'b0;
        end else begin
            v1  <= run;
            de1 <= req_valid;
            hs1 <= h_sync;
            vs1 <= v_sync;
        end
    end

    // pixel_in answers the previous cycle's request, so it lines up with the stage-1 flags here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lcd_hsync <= ~HSYNC_POL;
            lcd_vsync <= ~VSYNC_POL;
            lcd_de    <= 1'b0;
            lcd_rgb   <= '0;
        end else begin
            lcd_hsync <= (v1 & hs1) ? HSYNC_POL : ~HSYNC_POL;
            lcd_vsync <= (v1 & vs1) ? VSYNC_POL : ~VSYNC_POL;
            lcd_de    <= v1 & de1;
            lcd_rgb   <= (v1 & de1) ? pix_sel : '0;
        end
    end

endmodule
